// File: rtl/sdp_rd_pkg.sv
// Shared definitions for the BRAM read-side stream controller: RAM geometry,
// read latency of the pipelined BRAM and the controller FSM states.
package sdp_rd_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int RAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sdp_rd_fifo.sv
// Small shift-style FIFO: slot 0 is always the head, so the read data comes
// straight from a register. Carries RAM data plus the end-of-burst flag.
module sdp_rd_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [CNT_W-1:0] wr_idx;

  // A push in the same cycle as a pop lands one slot lower, as everything shifts down.
  assign wr_idx = count - CNT_W'(pop);
  assign rdata  = slot[0];
  assign valid  = (count != '0);

  // Shift on pop, write the incoming word at the first free slot, track occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) slot[i] <= slot[i+1];
        slot[DEPTH-1] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CNT_W'(i))) slot[i] <= wdata;
      end
    end
  end

endmodule

// File: rtl/sdp_stream_reader.sv
// Burst read controller for the pipelined simple-dual-port BRAM. Walks a run
// of read addresses and converts the fixed RAM read latency into a
// valid/ready stream, issuing reads only when the output buffer has room.
module sdp_stream_reader #(
  parameter int ADDR_W     = sdp_rd_pkg::ADDR_W,
  parameter int DATA_W     = sdp_rd_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_ceb,
  output logic              ram_oce,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  import sdp_rd_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  rd_state_e               state, state_nxt;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W:0]         remaining;
  logic                    zero_done;
  logic [RAM_RD_LAT:1]     vld_p;
  logic [RAM_RD_LAT:1]     last_p;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_W:0]         fifo_rdata;
  logic                    accept;
  logic                    issue;
  logic                    credit;
  logic                    pop;

  assign ram_oce = 1'b1;
  assign pop     = m_valid && m_ready;
  // A zero-length request still owes its done pulse; block new starts during it.
  assign accept  = (state == IDLE) && start && !zero_done;

  // Credit: words buffered plus words still inside the RAM pipeline, net of this cycle's pop.
  always_comb begin
    int occ;
    occ = int'(fifo_count) - int'(pop);
    for (int i = 1; i <= RAM_RD_LAT; i++) occ = occ + int'(vld_p[i]);
    credit = (occ < FIFO_DEPTH);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (len != '0))          state_nxt = RUN;
      RUN:     if (issue && (remaining == LEN_ONE)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last)                  state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read issue, status and completion pulse.
  always_comb begin
    busy    = (state != IDLE);
    issue   = (state == RUN) && credit;
    ram_ceb = issue;
    ram_adb = addr;
    done    = (pop && m_last) || zero_done;
  end

  // Burst address/count bookkeeping and the zero-length completion flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= accept && (len == '0);
      if (accept) begin
        addr      <= start_addr;
        remaining <= len;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_ONE;
      end
    end
  end

  // RAM pipeline tracker: stage N set means read data appears on ram_dout at stage RAM_RD_LAT.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p  <= {vld_p[RAM_RD_LAT-1:1], issue};
      last_p <= {last_p[RAM_RD_LAT-1:1], issue && (remaining == LEN_ONE)};
    end
  end

  sdp_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p[RAM_RD_LAT]),
    .wdata ({last_p[RAM_RD_LAT], ram_dout}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (m_valid),
    .count (fifo_count)
  );

  assign m_data = fifo_rdata[DATA_W-1:0];
  assign m_last = m_valid && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_sdp_stream_reader.sv
// Bench for sdp_stream_reader: behavioural BRAM, scoreboard of expected
// addresses and stream words, randomized backpressure and burst parameters.
module tb_sdp_stream_reader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] ram_adb;
  logic          ram_ceb, ram_oce;
  logic [DW-1:0] ram_dout;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  sdp_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_oce(ram_oce),
    .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  // Pipelined BRAM read port: ceb gates the array read, oce gates the output register.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_s1, ram_q;
  always @(posedge clk) begin
    if (ram_ceb) ram_s1 <= mem[ram_adb];
    if (ram_oce) ram_q  <= ram_s1;
  end
  assign ram_dout = ram_q;

  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] adr_q [$];
  int outstanding = 0;
  int pops = 0;
  int done_seen = 0;
  int done_exp = 0;
  int ready_mode = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected addresses and words come straight from the burst definition.
  task automatic launch(input logic [AW-1:0] a, input logic [AW:0] n);
    logic [AW-1:0] ad;
    for (int i = 0; i < int'(n); i++) begin
      ad = a + AW'(i);
      adr_q.push_back(ad);
      exp_q.push_back({(i == int'(n) - 1), mem[ad]});
    end
    done_exp++;
    start = 1'b1; start_addr = a; len = n;
  endtask

  task automatic start_off();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && adr_q.size() == 0 && !busy) break;
    end
    chk("burst_finished_in_budget", (k < budget), 1);
    chk("done_count", done_seen, done_exp);
    @(posedge clk); #1;
  endtask

  // Backpressure generator.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every issued read and every accepted word against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (ram_ceb) begin
          chk("read_expected", (adr_q.size() > 0), 1);
          if (adr_q.size() > 0) chk("ram_adb", ram_adb, adr_q.pop_front());
          outstanding++;
        end
        if (m_valid && m_ready) begin
          chk("word_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e[DW-1:0]);
            chk("m_last", m_last, e[DW]);
            chk("done_on_pop", done, e[DW]);
          end
          outstanding--;
          pops++;
        end
        if (done) done_seen++;
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, prev_data);
          chk("stall_last", m_last, prev_last);
        end
        if (ram_ceb || (m_valid && m_ready)) chk("outstanding_le_depth", (outstanding <= FD), 1);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int k;
    logic [AW-1:0] a;
    logic [AW:0]   n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; start_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_ram_ceb", ram_ceb, 0);
    chk("rst_ram_adb", ram_adb, 0);
    chk("rst_ram_oce", ram_oce, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cycle-accurate burst: start in cycle 0.
    launch(8'h10, 9'd4);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("t1_ram_ceb", ram_ceb, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("t1_ram_adb", ram_adb, 8'h10 + c - 1);
      chk("t1_m_valid", m_valid, (c >= 4 && c <= 7));
      chk("t1_m_last", m_last, (c == 7));
      chk("t1_done", done, (c == 7));
      chk("t1_busy", busy, (c >= 1 && c <= 7));
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
    end
    wait_idle(20);

    // Zero-length request, with a second start landing on the done cycle.
    launch(8'h33, 9'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t0_ram_ceb", ram_ceb, 0);
      chk("t0_busy", busy, 0);
      chk("t0_done", done, (c == 1));
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; start_addr = 8'h70; len = 9'd3;
      end else begin
        start = 1'b0;
      end
    end
    wait_idle(20);

    // Address wrap.
    launch(8'hFE, 9'd4);
    start_off();
    wait_idle(50);

    // Long stall followed by random backpressure.
    ready_mode = 2;
    launch(8'h40, 9'd16);
    start_off();
    repeat (10) @(posedge clk);
    #1 ready_mode = 1;
    wait_idle(400);

    // Random bursts under random backpressure.
    for (int r = 0; r < 6; r++) begin
      ready_mode = int'($urandom_range(0, 1));
      a = AW'($urandom);
      n = 9'($urandom_range(1, 40));
      launch(a, n);
      start_off();
      wait_idle(600);
    end

    // Full-size burst.
    ready_mode = 0;
    launch(8'h80, 9'd256);
    start_off();
    wait_idle(600);

    // Reset in the middle of a burst after three accepted words.
    launch(8'h20, 9'd8);
    start_off();
    base = pops;
    for (k = 0; k < 40; k++) begin
      if (pops >= base + 3) break;
      @(posedge clk); #1;
    end
    chk("mid_reset_reached", (k < 40), 1);
    reset = 1'b1;
    exp_q.delete();
    adr_q.delete();
    outstanding = 0;
    done_exp = done_seen;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_ram_ceb", ram_ceb, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_done", done_seen, done_exp);
    ready_mode = 1;
    launch(8'h20, 9'd8);
    start_off();
    wait_idle(200);

    // Start while busy must be ignored.
    launch(8'h50, 9'd8);
    start_off();
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 8'h99; len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(200);

    repeat (5) @(posedge clk);
    chk("final_done_count", done_seen, done_exp);
    chk("final_words_left", exp_q.size(), 0);
    chk("final_reads_left", adr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
